// File: rtl/tuart_rx_cmd_pkg.sv
// Shared types and constants for the SUMP command receiver.
// Build option: TUART_RX_PARITY_EN adds a parity bit between data and stop.
package tuart_rx_cmd_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int   DIV_MIN        = 2;
  // SUMP opcodes with this MSB carry no payload.
  localparam logic SUMP_SHORT_MSB = 1'b0;

  function automatic logic is_short_opcode(input logic msb);
    return msb == SUMP_SHORT_MSB;
  endfunction

endpackage

// File: rtl/tuart_rx_cmd_if.sv
// Bus between the rx synchroniser side and the command decoder side.
// Build option: TUART_RX_PARITY_EN adds parity_odd_i and err_parity_o.
interface tuart_rx_cmd_if
  import tuart_rx_cmd_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int CMD_WORDS = 5,
  parameter int DIV_W     = 16
);
  logic                           rx_sync_i;
  logic [DIV_W-1:0]               clk_per_bit_i;
`ifdef TUART_RX_PARITY_EN
  logic                           parity_odd_i;
  logic                           err_parity_o;
`endif
  // data_o/long_o are valid in the cycle stb_o is high and hold until the next stb_o;
  // there is no back-pressure, the consumer must take every stb_o.
  logic [WORD_BITS*CMD_WORDS-1:0] data_o;
  logic                           long_o;
  logic                           stb_o;
  logic                           err_frame_o;
  logic                           err_timeout_o;
  rx_state_t                      state_o;

  modport master (
`ifdef TUART_RX_PARITY_EN
    output parity_odd_i,
    input  err_parity_o,
`endif
    output rx_sync_i, clk_per_bit_i,
    input  data_o, long_o, stb_o, err_frame_o, err_timeout_o, state_o
  );

  modport slave (
`ifdef TUART_RX_PARITY_EN
    input  parity_odd_i,
    output err_parity_o,
`endif
    input  rx_sync_i, clk_per_bit_i,
    output data_o, long_o, stb_o, err_frame_o, err_timeout_o, state_o
  );
endinterface

// File: rtl/tuart_rx_cmd_bitclk.sv
// Bit-time generator: latches the divisor at start detection and emits the
// sample tick at half a bit (start bit) or a full bit (all later bits).
module tuart_rx_cmd_bitclk
  import tuart_rx_cmd_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             half_i,
  input  logic [DIV_W-1:0] clk_per_bit_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] smpl_cnt_q, smpl_cnt_d;
  logic [DIV_W-1:0] limit;

  always_comb begin
    div_d = div_q;
    if (start_i) begin
      div_d = (clk_per_bit_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : clk_per_bit_i;
    end
    limit  = half_i ? ((div_q >> 1) - DIV_W'(1)) : (div_q - DIV_W'(1));
    tick_o = run_i && (smpl_cnt_q == limit);
    smpl_cnt_d = smpl_cnt_q + DIV_W'(1);
    if (start_i || !run_i || tick_o) begin
      smpl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      div_q      <= '0;
      smpl_cnt_q <= '0;
    end else begin
      div_q      <= div_d;
      smpl_cnt_q <= smpl_cnt_d;
    end
  end
endmodule

// File: rtl/tuart_rx_cmd.sv
// SUMP command receiver: UART deserialiser plus short/long command assembly.
// Build option: TUART_RX_PARITY_EN enables the parity bit and err_parity_o.
module tuart_rx_cmd
  import tuart_rx_cmd_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int CMD_WORDS = 5,
  parameter int DIV_W     = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic         clk_i,
  input  logic         rst_in,
  tuart_rx_cmd_if.slave bus
);
  localparam int BIT_W  = $clog2(WORD_BITS + 1);
  localparam int WCNT_W = $clog2(CMD_WORDS + 1);
  localparam int CMD_W  = WORD_BITS * CMD_WORDS;
  localparam int ACC_W  = WORD_BITS * (CMD_WORDS - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  rx_state_t              state_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [WCNT_W-1:0]      word_cnt_q;
  logic [TIMEOUT_W-1:0]   to_cnt_q;
  logic [WORD_BITS-1:0]   word_q;
  logic [ACC_W-1:0]       cmd_q;
  logic [CMD_W-1:0]       data_q;
  logic                   long_q, stb_q, err_frame_q, err_timeout_q;
  logic                   start_det, tick;
`ifdef TUART_RX_PARITY_EN
  logic                   par_bad_q, err_parity_q;
  assign bus.err_parity_o = err_parity_q;
`endif

  assign start_det = (state_q == IDLE) && !bus.rx_sync_i;

  tuart_rx_cmd_bitclk #(.DIV_W(DIV_W)) u_bitclk (
    .clk_i         (clk_i),
    .rst_in        (rst_in),
    .start_i       (start_det),
    .run_i         (state_q != IDLE),
    .half_i        (state_q == START),
    .clk_per_bit_i (bus.clk_per_bit_i),
    .tick_o        (tick)
  );

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      to_cnt_q      <= '0;
      word_q        <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      long_q        <= 1'b0;
      stb_q         <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef TUART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      err_parity_q  <= 1'b0;
`endif
    end else begin
      stb_q         <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef TUART_RX_PARITY_EN
      err_parity_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!bus.rx_sync_i) begin
            state_q  <= START;
            to_cnt_q <= '0;
          end else if (word_cnt_q != '0) begin
            if (to_cnt_q == TO_LAST) begin
              err_timeout_q <= 1'b1;
              word_cnt_q    <= '0;
              to_cnt_q      <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        START: if (tick) begin
          // A start bit that is high at mid-bit was noise: drop it silently.
          state_q   <= bus.rx_sync_i ? IDLE : DATA;
          bit_cnt_q <= '0;
        end
        DATA: if (tick) begin
          word_q    <= {bus.rx_sync_i, word_q[WORD_BITS-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
`ifdef TUART_RX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end
        end
`ifdef TUART_RX_PARITY_EN
        PARITY: if (tick) begin
          par_bad_q <= bus.rx_sync_i ^ (^word_q) ^ bus.parity_odd_i;
          state_q   <= STOP;
        end
`endif
        STOP: if (tick) begin
          // Back to IDLE at mid stop bit so the next start edge is never missed.
          state_q <= IDLE;
          if (!bus.rx_sync_i) begin
            err_frame_q <= 1'b1;
            word_cnt_q  <= '0;
`ifdef TUART_RX_PARITY_EN
          end else if (par_bad_q) begin
            err_parity_q <= 1'b1;
            word_cnt_q   <= '0;
`endif
          end else if (word_cnt_q == '0 && is_short_opcode(word_q[WORD_BITS-1])) begin
            data_q     <= {word_q, {(CMD_W-WORD_BITS){1'b0}}};
            long_q     <= 1'b0;
            stb_q      <= 1'b1;
          end else if (word_cnt_q == WCNT_W'(CMD_WORDS - 1)) begin
            data_q     <= {cmd_q, word_q};
            long_q     <= 1'b1;
            stb_q      <= 1'b1;
            word_cnt_q <= '0;
          end else begin
            cmd_q      <= ACC_W'({cmd_q, word_q});
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o        = data_q;
  assign bus.long_o        = long_q;
  assign bus.stb_o         = stb_q;
  assign bus.err_frame_o   = err_frame_q;
  assign bus.err_timeout_o = err_timeout_q;
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_tuart_rx_cmd.sv
// Bench for tuart_rx_cmd: directed frame table, corner sequences and random
// frames against a word-level command model.
module tb_tuart_rx_cmd;
  import tuart_rx_cmd_pkg::*;

  localparam int DATA_W = 40;
  localparam int EV_W   = 3 + 1 + DATA_W;
  localparam logic [2:0] K_NONE = 3'd0, K_STB = 3'd1, K_FERR = 3'd2, K_TOUT = 3'd3, K_PERR = 3'd4;

  typedef struct {
    int          cpb;
    logic [7:0]  b;
    logic        stop;
    int          gap;
    logic [2:0]  kind;
    logic        lng;
    logic [DATA_W-1:0] data;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [EV_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_data = '0;
  logic [EV_W-1:0] obs, expv;
  int n_ev;
  logic [7:0] words[$];

  tuart_rx_cmd_if #(.WORD_BITS(8), .CMD_WORDS(5), .DIV_W(16)) bus ();

  tuart_rx_cmd #(.WORD_BITS(8), .CMD_WORDS(5), .DIV_W(16), .TIMEOUT_W(6)) u_dut (
    .clk_i  (clk_i),
    .rst_in (rst_n),
    .bus    (bus.slave)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic void push_ev(input logic [2:0] kind, input logic lng, input logic [DATA_W-1:0] d);
    if (kind == K_STB) begin
      exp_q.push_back({kind, lng, d});
      last_data = d;
    end else if (kind != K_NONE) begin
      exp_q.push_back({kind, 1'b0, {DATA_W{1'b0}}});
    end
  endfunction

  // driver tasks
  task automatic hold(input logic v, input int n);
    bus.rx_sync_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input int cpb, input logic [7:0] b, input logic stop, input int new_cpb);
    int bt;
    bt = (cpb < 2) ? 2 : cpb;
    bus.clk_per_bit_i = 16'(cpb);
    hold(1'b0, bt);
    if (new_cpb >= 0) bus.clk_per_bit_i = 16'(new_cpb);
    for (int i = 0; i < 8; i++) hold(b[i], bt);
`ifdef TUART_RX_PARITY_EN
    hold(^b, bt);
`endif
    hold(stop, bt);
    bus.rx_sync_i = 1'b1;
  endtask

  // word-level reference model: frame outcome -> expected events
  function automatic void model_frame(input logic [7:0] b, input logic stop);
    logic [DATA_W-1:0] d;
    if (!stop) begin
      push_ev(K_FERR, 1'b0, '0);
      words.delete();
      return;
    end
    words.push_back(b);
    if (words.size() == 1 && b[7] == 1'b0) begin
      push_ev(K_STB, 1'b0, {b, 32'h0});
      words.delete();
    end else if (words.size() == 5) begin
      d = '0;
      foreach (words[i]) d = (d << 8) | DATA_W'(words[i]);
      push_ev(K_STB, 1'b1, d);
      words.delete();
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (rst_n) begin
      n_ev = int'(bus.stb_o) + int'(bus.err_frame_o) + int'(bus.err_timeout_o);
`ifdef TUART_RX_PARITY_EN
      n_ev += int'(bus.err_parity_o);
`endif
      if (n_ev != 0) begin
        if (bus.stb_o) obs = {K_STB, bus.long_o, bus.data_o};
        else if (bus.err_frame_o) obs = {K_FERR, 1'b0, {DATA_W{1'b0}}};
        else if (bus.err_timeout_o) obs = {K_TOUT, 1'b0, {DATA_W{1'b0}}};
        else obs = {K_PERR, 1'b0, {DATA_W{1'b0}}};
        checks++;
        if (n_ev > 1) begin
          errors++;
          $display("FAIL event_coincide: got %0d pulses required 1", n_ev);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: got %h required no event", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL event: got %h required %h", obs, expv);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];

  initial begin
    int lat, bad, cpb, gap;
    logic [7:0] b;
    logic stop;

    tbl[0]  = '{4,  8'h01, 1'b1, 4, K_STB,  1'b0, 40'h0100000000};
    tbl[1]  = '{10, 8'h80, 1'b1, 2, K_NONE, 1'b0, 40'h0};
    tbl[2]  = '{10, 8'h11, 1'b1, 0, K_NONE, 1'b0, 40'h0};
    tbl[3]  = '{10, 8'h22, 1'b1, 3, K_NONE, 1'b0, 40'h0};
    tbl[4]  = '{10, 8'h33, 1'b1, 1, K_NONE, 1'b0, 40'h0};
    tbl[5]  = '{10, 8'h44, 1'b1, 4, K_STB,  1'b1, 40'h8011223344};
    tbl[6]  = '{4,  8'h80, 1'b1, 2, K_NONE, 1'b0, 40'h0};
    tbl[7]  = '{4,  8'h81, 1'b0, 8, K_FERR, 1'b0, 40'h0};
    tbl[8]  = '{4,  8'h00, 1'b1, 4, K_STB,  1'b0, 40'h0};
    tbl[9]  = '{1,  8'h05, 1'b1, 4, K_STB,  1'b0, 40'h0500000000};
    tbl[10] = '{0,  8'h9A, 1'b1, 3, K_NONE, 1'b0, 40'h0};
    tbl[11] = '{7,  8'h01, 1'b1, 2, K_NONE, 1'b0, 40'h0};
    tbl[12] = '{7,  8'h02, 1'b1, 2, K_NONE, 1'b0, 40'h0};
    tbl[13] = '{3,  8'h03, 1'b1, 2, K_NONE, 1'b0, 40'h0};
    tbl[14] = '{12, 8'hFF, 1'b1, 5, K_STB,  1'b1, 40'h9A010203FF};

    bus.rx_sync_i = 1'b1;
    bus.clk_per_bit_i = 16'd4;
`ifdef TUART_RX_PARITY_EN
    bus.parity_odd_i = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    chk("reset_data", 64'(bus.data_o), 64'h0);
    chk("reset_flags", {60'h0, bus.long_o, bus.stb_o, bus.err_frame_o, bus.err_timeout_o}, 64'h0);
    chk("reset_state", 64'(bus.state_o), 64'(IDLE));
    rst_n = 1'b1;
    repeat (4) @(negedge clk_i);

    // directed frame table
    for (int i = 0; i < 15; i++) begin
      push_ev(tbl[i].kind, tbl[i].lng, tbl[i].data);
      send_frame(tbl[i].cpb, tbl[i].b, tbl[i].stop, -1);
      hold(1'b1, tbl[i].gap);
    end
    hold(1'b1, 20);
    chk("data_hold", 64'(bus.data_o), 64'(last_data));

    // start glitch: 2 clocks low at div=8
    bus.clk_per_bit_i = 16'd8;
    bad = 0;
    bus.rx_sync_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) bus.rx_sync_i = 1'b1;
      @(negedge clk_i);
      if (bus.state_o != IDLE && bus.state_o != START) bad++;
    end
    chk("glitch_no_data_state", 64'(bad), 64'h0);
    push_ev(K_STB, 1'b0, 40'h0200000000);
    send_frame(8, 8'h02, 1'b1, -1);
    hold(1'b1, 6);

    // divisor change mid-frame is ignored
    push_ev(K_STB, 1'b0, 40'h0400000000);
    send_frame(6, 8'h04, 1'b1, 20);
    hold(1'b1, 6);

    // inter-word timeout
    send_frame(4, 8'h80, 1'b1, -1);
    push_ev(K_TOUT, 1'b0, '0);
    lat = 0;
    while (!bus.err_timeout_o && lat < 150) begin
      @(negedge clk_i);
      lat++;
    end
    chk("timeout_in_window", 64'(lat >= 55 && lat <= 70), 64'h1);
    hold(1'b1, 5);
    push_ev(K_STB, 1'b0, 40'h0100000000);
    send_frame(4, 8'h01, 1'b1, -1);
    hold(1'b1, 6);

    // reset in the middle of a command and a frame
    send_frame(4, 8'h80, 1'b1, -1);
    hold(1'b0, 4);
    hold(1'b1, 4);
    hold(1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_data", 64'(bus.data_o), 64'h0);
    chk("async_reset_state", 64'(bus.state_o), 64'(IDLE));
    bus.rx_sync_i = 1'b1;
    @(negedge clk_i);
    rst_n = 1'b1;
    hold(1'b1, 10);
    push_ev(K_STB, 1'b0, 40'h0100000000);
    send_frame(4, 8'h01, 1'b1, -1);
    hold(1'b1, 6);

    // random frames against the model
    words.delete();
    for (int n = 0; n < 40; n++) begin
      cpb = $urandom_range(0, 12);
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 9) != 0);
      gap = ($urandom_range(0, 7) == 0) ? 90 : $urandom_range(0, 15);
      if (gap >= 80 && words.size() != 0) begin
        push_ev(K_TOUT, 1'b0, '0);
        words.delete();
      end
      hold(1'b1, gap);
      model_frame(b, stop);
      send_frame(cpb, b, stop, -1);
      if (!stop) hold(1'b1, 14);
    end
    if (words.size() != 0) begin
      push_ev(K_TOUT, 1'b0, '0);
      words.delete();
    end
    hold(1'b1, 120);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    chk("final_data_hold", 64'(bus.data_o), 64'(last_data));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
